bit_serializer: RTL and testbench

Parallel-to-serial front end for the pattern-detection path. Accepts WORD_W-bit words over a valid/ready handshake and emits them one bit per clock on a serial line that drives the pattern detector's `data_in`. Words are sent gap-free when the upstream source keeps up. The line drives 0 when no word is available.

---
 rtl/ser_pkg.sv | 20 ++
 rtl/bit_serializer.sv | 110 +++++++++++
 tb/tb_bit_serializer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// ============================================================================
// Module      : ser_pkg
// Description : Shared types and constants for the bit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int SER_WORD_W_DEF = 8;
   localparam int SER_CNT_W      = 16;

endpackage : ser_pkg

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial front end, one bit per clock, gap-free when
//               fed continuously. Define SER_STALL_EN to add bit_ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
   import ser_pkg::*;
#(
   parameter int WORD_W = SER_WORD_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_W-1:0]    word_in,
   input  logic                 word_valid,
   output logic                 word_ready,
   input  logic                 lsb_first,
`ifdef SER_STALL_EN
   input  logic                 bit_ready,
`endif
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic                 busy,
   output logic [SER_CNT_W-1:0] words_sent
);

   localparam int              CNT_W    = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

   ser_state_t           state_q;
   logic [WORD_W-1:0]    shreg_q;
   logic [WORD_W-1:0]    shreg_d;
   logic [CNT_W-1:0]     idx_q;
   logic                 lsb_q;
   logic                 bit_out_q;
   logic                 bit_valid_q;
   logic                 busy_q;
   logic [SER_CNT_W-1:0] words_sent_q;

   logic bit_rdy;
   logic consume;
   logic last;
   logic accept;
   logic next_bit_d;
   logic load_bit_d;

`ifdef SER_STALL_EN
   assign bit_rdy = bit_ready;
`else
   assign bit_rdy = 1'b1;
`endif

   assign consume    = (state_q == SHIFT) & bit_valid_q & bit_rdy;
   assign last       = (idx_q == LAST_IDX);
   assign word_ready = ~rst & ((state_q == IDLE) | (consume & last));
   assign accept     = word_valid & word_ready;

   // The register shifts toward the output end so the next bit always sits next to it.
   assign shreg_d    = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
   assign next_bit_d = lsb_q ? shreg_q[1] : shreg_q[WORD_W-2];
   assign load_bit_d = lsb_first ? word_in[0] : word_in[WORD_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         idx_q        <= '0;
         lsb_q        <= 1'b0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         words_sent_q <= '0;
      end else begin
         if (consume && last) begin
            words_sent_q <= words_sent_q + SER_CNT_W'(1);
         end

         if (accept) begin
            state_q     <= SHIFT;
            shreg_q     <= word_in;
            lsb_q       <= lsb_first;
            idx_q       <= '0;
            bit_out_q   <= load_bit_d;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
         end else if (consume) begin
            if (last) begin
               state_q     <= IDLE;
               bit_out_q   <= 1'b0;
               bit_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end else begin
               idx_q     <= idx_q + CNT_W'(1);
               shreg_q   <= shreg_d;
               bit_out_q <= next_bit_d;
            end
         end
      end
   end

   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign busy       = busy_q;
   assign words_sent = words_sent_q;

endmodule : bit_serializer

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer (WORD_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  word_in;
   logic        word_valid;
   logic        word_ready;
   logic        lsb_first;
   logic        bit_ready;
   logic        bit_out;
   logic        bit_valid;
   logic        busy;
   logic [15:0] words_sent;

   int n_checks = 0;
   int n_errors = 0;

   bit_serializer #(.WORD_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .lsb_first  (lsb_first),
`ifdef SER_STALL_EN
      .bit_ready  (bit_ready),
`endif
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expects a word already accepted on the previous edge; walks its 8 bits.
   task automatic expect_bits(input string tag, input logic [7:0] pat);
      logic [7:0] p;
      p = pat;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_valid"}, 32'(bit_valid), 32'd1);
         chk({tag, "_bit"},   32'(bit_out),   32'(p[7-i]));
         chk({tag, "_busy"},  32'(busy),      32'd1);
         chk({tag, "_rdy"},   32'(word_ready), (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   initial begin
      logic [15:0] pair;
      rst        = 1'b1;
      word_in    = 8'h00;
      word_valid = 1'b0;
      lsb_first  = 1'b0;
      bit_ready  = 1'b1;

      // Reset held three cycles
      repeat (3) tick();
      chk("rst_bit_out",    32'(bit_out),    32'd0);
      chk("rst_bit_valid",  32'(bit_valid),  32'd0);
      chk("rst_word_ready", 32'(word_ready), 32'd0);
      chk("rst_words_sent", 32'(words_sent), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      rst = 1'b0;
      #1;
      chk("idle_word_ready", 32'(word_ready), 32'd1);

      // MSB-first 8'hB0 -> 1,0,1,1,0,0,0,0
      word_in = 8'hB0; word_valid = 1'b1; lsb_first = 1'b0;
      tick();
      word_valid = 1'b0;
      expect_bits("msb", 8'b1011_0000);
      chk("msb_idle_valid", 32'(bit_valid),  32'd0);
      chk("msb_idle_out",   32'(bit_out),    32'd0);
      chk("msb_count",      32'(words_sent), 32'd1);
      chk("msb_idle_rdy",   32'(word_ready), 32'd1);

      // LSB-first 8'h0D -> 1,0,1,1,0,0,0,0; inputs scrambled mid-word
      word_in = 8'h0D; word_valid = 1'b1; lsb_first = 1'b1;
      tick();
      word_valid = 1'b0; lsb_first = 1'b0; word_in = 8'h5A;
      expect_bits("lsb", 8'b1011_0000);
      chk("lsb_count", 32'(words_sent), 32'd2);

      // Back-to-back 8'hA5 then 8'h3C, valid held high
      pair = 16'hA53C;
      word_in = 8'hA5; word_valid = 1'b1; lsb_first = 1'b0;
      tick();
      word_in = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_valid", 32'(bit_valid), 32'd1);
         chk("b2b_bit",   32'(bit_out),   32'(pair[15-i]));
         chk("b2b_rdy",   32'(word_ready), (i == 7 || i == 15) ? 32'd1 : 32'd0);
         tick();
         if (i == 7) word_valid = 1'b0;
      end
      chk("b2b_idle_valid", 32'(bit_valid),  32'd0);
      chk("b2b_count",      32'(words_sent), 32'd4);

      // Reset after three bits of 8'hFF
      word_in = 8'hFF; word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      repeat (3) tick();
      chk("mid_pre_valid", 32'(bit_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(bit_valid),  32'd0);
      chk("mid_rst_count", 32'(words_sent), 32'd0);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      rst = 1'b0;
      #1;
      chk("mid_rdy", 32'(word_ready), 32'd1);
      word_in = 8'h81; word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      expect_bits("reacc", 8'b1000_0001);
      chk("reacc_count", 32'(words_sent), 32'd1);

`ifdef SER_STALL_EN
      // Stall four cycles after two bits of 8'hB0; word takes 12 cycles
      word_in = 8'hB0; word_valid = 1'b1; lsb_first = 1'b0;
      tick();
      word_valid = 1'b0;
      chk("stl_b0", 32'(bit_out), 32'd1);
      tick();
      chk("stl_b1", 32'(bit_out), 32'd0);
      tick();
      bit_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("stl_hold_bit",   32'(bit_out),   32'd1);
         chk("stl_hold_valid", 32'(bit_valid), 32'd1);
         tick();
      end
      bit_ready = 1'b1;
      pair = 16'h00B0;
      for (int i = 2; i < 8; i++) begin
         chk("stl_bit", 32'(bit_out), 32'(pair[7-i]));
         tick();
      end
      chk("stl_done_valid", 32'(bit_valid),  32'd0);
      chk("stl_count",      32'(words_sent), 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_bit_serializer

`default_nettype wire
